// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces the stopwatch buttons/switches, producing SEL/ADJ levels, a toggled PAUSE and a one-cycle reset pulse.
//
// Ports:
//    clk        in   system clock
//    rst        in   asynchronous active-low reset
//    btn_pause  in   raw pause button, 1 = pressed
//    btn_rst    in   raw reset button, 1 = pressed
//    sw_sel     in   raw SEL slide switch
//    sw_adj     in   raw ADJ slide switch
//    PAUSE      out  pause level, toggles on each accepted pause press
//    rst_out    out  one-cycle active-high pulse on each accepted reset press
//    SEL        out  debounced sw_sel
//    ADJ        out  debounced sw_adj
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_pause,
   input  logic btn_rst,
   input  logic sw_sel,
   input  logic sw_adj,
   output logic PAUSE,
   output logic rst_out,
   output logic SEL,
   output logic ADJ
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {RUN, HOLD} state_t;

   // channel order: 0 pause, 1 reset, 2 sel, 3 adj
   logic [3:0]       raw;
   logic [3:0]       s1_q, s2_q;
   logic [3:0]       stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       rise_d;
   logic             rst_out_q, rst_out_d;
   state_t           state_q, state_d;

   assign raw = {sw_adj, sw_sel, btn_rst, btn_pause};

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == LAST) stable_d[i] = s2_q[i];
            else cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Edge detection compares the accepted next level with the current one, so the
   // pulse and the PAUSE toggle register on the same edge the stable bit changes.
   assign rise_d    = stable_d & ~stable_q;
   assign rst_out_d = rise_d[1];

   // reset press has priority over a simultaneous pause press
   always_comb begin
      state_d = state_q;
      if (rise_d[1]) state_d = RUN;
      else if (rise_d[0]) state_d = (state_q == RUN) ? HOLD : RUN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         stable_q  <= '0;
         rst_out_q <= 1'b0;
         state_q   <= RUN;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         s1_q      <= raw;
         s2_q      <= s1_q;
         stable_q  <= stable_d;
         rst_out_q <= rst_out_d;
         state_q   <= state_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign PAUSE   = (state_q == HOLD);
   assign rst_out = rst_out_q;
   assign SEL     = stable_q[2];
   assign ADJ     = stable_q[3];
endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;
   logic clk = 1'b0;
   logic rst, btn_pause, btn_rst, sw_sel, sw_adj;
   logic PAUSE, rst_out, SEL, ADJ;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   button_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_rst(btn_rst),
      .sw_sel(sw_sel), .sw_adj(sw_adj), .PAUSE(PAUSE), .rst_out(rst_out),
      .SEL(SEL), .ADJ(ADJ)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic p, input logic r, input logic s, input logic a);
      chk({tag, ".PAUSE"}, PAUSE, p);
      chk({tag, ".rst_out"}, rst_out, r);
      chk({tag, ".SEL"}, SEL, s);
      chk({tag, ".ADJ"}, ADJ, a);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; btn_pause = 1'b0; btn_rst = 1'b0; sw_sel = 1'b0; sw_adj = 1'b0;
      repeat (3) tick();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      // idle
      for (int k = 0; k < 20; k++) begin
         tick();
         chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      // SEL switch: accepted exactly 6 cycles after the raw edge
      sw_sel = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("sel_early", SEL, 1'b0);
         chk("adj_quiet", ADJ, 1'b0);
      end
      tick();
      chk("sel_accept", SEL, 1'b1);
      chk("adj_quiet", ADJ, 1'b0);
      repeat (2) tick();
      chk("sel_hold", SEL, 1'b1);
      // pause bounce then steady press
      btn_pause = 1'b1; tick(); chk("bounce", PAUSE, 1'b0);
      btn_pause = 1'b0; tick(); chk("bounce", PAUSE, 1'b0);
      btn_pause = 1'b1; tick(); chk("bounce", PAUSE, 1'b0);
      btn_pause = 1'b0; tick(); chk("bounce", PAUSE, 1'b0);
      btn_pause = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("pause_early", PAUSE, 1'b0);
      end
      tick();
      chk("pause_on", PAUSE, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("pause_held", PAUSE, 1'b1);
      end
      // release keeps PAUSE, second press toggles back
      btn_pause = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("pause_release", PAUSE, 1'b1);
      end
      btn_pause = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("pause2_early", PAUSE, 1'b1);
      end
      tick();
      chk("pause_off", PAUSE, 1'b0);
      btn_pause = 1'b0;
      repeat (6) tick();
      // third press sets PAUSE=1 for the reset test
      btn_pause = 1'b1;
      repeat (6) tick();
      chk("pause_on2", PAUSE, 1'b1);
      btn_pause = 1'b0;
      repeat (6) tick();
      chk("pause_on2_rel", PAUSE, 1'b1);
      // reset button held 20 cycles: single pulse, PAUSE cleared the same cycle
      btn_rst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("rst_pulse", rst_out, k == 6);
         chk("rst_pause", PAUSE, k < 6);
      end
      btn_rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rst_release", rst_out, 1'b0);
      end
      // simultaneous pause and reset press: reset wins
      btn_pause = 1'b1; btn_rst = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("both_pulse", rst_out, k == 6);
         chk("both_pause", PAUSE, 1'b0);
      end
      btn_pause = 1'b0; btn_rst = 1'b0;
      repeat (6) tick();
      chk("both_after", PAUSE, 1'b0);
      chk("sel_still", SEL, 1'b1);
      // async reset mid-count (cnt=2), between clock edges
      btn_pause = 1'b1;
      repeat (4) tick();
      chk("pre_async", PAUSE, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("async_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("post_rst_early", PAUSE, 1'b0);
         chk("post_rst_sel_early", SEL, 1'b0);
      end
      tick();
      chk("post_rst_pause", PAUSE, 1'b1);
      chk("post_rst_sel", SEL, 1'b1);
      chk("post_rst_pulse", rst_out, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
